// File: rtl/full_adder_pkg.sv
// Shared helpers for the pipelined adder: chunk sizing and parameter legality.
package full_adder_pkg;

    // Bits handled by each pipeline stage; clamped so illegal settings still elaborate far enough to report.
    function automatic int chunk_w(input int width, input int stages);
        if (stages < 1 || width < 1 || stages > width) begin
            return 1;
        end
        return width / stages;
    endfunction

    function automatic bit params_legal(input int width, input int stages);
        return (width >= 1) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Combinational 1-bit full adder cell used as the ripple element inside each stage.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ c;
    assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/full_adder.sv
// Pipelined ripple-carry adder: {cout, A} = x + y + cin, one chunk per stage,
// operands skewed in and chunk sums deskewed out so every result emerges aligned.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] A,
    output logic             cout
);

    localparam int CHUNK = chunk_w(WIDTH, STAGES);

    logic [STAGES-1:0] w_carry;
    logic [WIDTH-1:0]  w_sum;

    if (!params_legal(WIDTH, STAGES)) begin : g_bad_params
        $error("full_adder: need 1 <= STAGES <= WIDTH and WIDTH %% STAGES == 0");
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int SKEW = s;
        localparam int DSK  = STAGES - 1 - s;

        logic [CHUNK-1:0] w_a;
        logic [CHUNK-1:0] w_b;
        logic [CHUNK-1:0] w_s;
        logic [CHUNK:0]   w_c;
        logic [CHUNK-1:0] r_sum;
        logic             r_co;

        if (s == 0) begin : g_head
            assign w_a    = x[CHUNK-1:0];
            assign w_b    = y[CHUNK-1:0];
            assign w_c[0] = cin;
        end else begin : g_skew
            // Chunk s waits s cycles so it meets the carry produced by stage s-1.
            logic [CHUNK-1:0] r_xs [SKEW];
            logic [CHUNK-1:0] r_ys [SKEW];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int d = 0; d < SKEW; d++) begin
                        r_xs[d] <= '0;
                        r_ys[d] <= '0;
                    end
                end else begin
                    r_xs[0] <= x[s*CHUNK +: CHUNK];
                    r_ys[0] <= y[s*CHUNK +: CHUNK];
                    for (int d = 1; d < SKEW; d++) begin
                        r_xs[d] <= r_xs[d-1];
                        r_ys[d] <= r_ys[d-1];
                    end
                end
            end

            assign w_a    = r_xs[SKEW-1];
            assign w_b    = r_ys[SKEW-1];
            assign w_c[0] = w_carry[s-1];
        end

        for (genvar i = 0; i < CHUNK; i++) begin : g_bit
            full_adder_cell u_cell (
                .a  (w_a[i]),
                .b  (w_b[i]),
                .c  (w_c[i]),
                .s  (w_s[i]),
                .co (w_c[i+1])
            );
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_sum <= '0;
                r_co  <= 1'b0;
            end else begin
                r_sum <= w_s;
                r_co  <= w_c[CHUNK];
            end
        end

        assign w_carry[s] = r_co;

        if (DSK == 0) begin : g_last
            assign w_sum[s*CHUNK +: CHUNK] = r_sum;
        end else begin : g_deskew
            // Early chunks are held back until the final stage catches up.
            logic [CHUNK-1:0] r_ds [DSK];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int d = 0; d < DSK; d++) begin
                        r_ds[d] <= '0;
                    end
                end else begin
                    r_ds[0] <= r_sum;
                    for (int d = 1; d < DSK; d++) begin
                        r_ds[d] <= r_ds[d-1];
                    end
                end
            end

            assign w_sum[s*CHUNK +: CHUNK] = r_ds[DSK-1];
        end
    end

    assign A    = w_sum;
    assign cout = w_carry[STAGES-1];

endmodule

// File: tb/tb_full_adder.sv
// Directed and randomized checks of full_adder in several WIDTH/STAGES configurations.
module tb_full_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [0:0]  x1, y1, a1;
    logic        c1, co1;
    logic [7:0]  x84, y84, a84;
    logic        c84, co84;
    logic [7:0]  x82, y82, a82;
    logic        c82, co82;
    logic [15:0] x164, y164, a164;
    logic        c164, co164;
    logic [7:0]  x88, y88, a88;
    logic        c88, co88;

    full_adder #(.WIDTH(1), .STAGES(1)) u_d1 (
        .clk(clk), .rst(rst), .x(x1), .y(y1), .cin(c1), .A(a1), .cout(co1));
    full_adder #(.WIDTH(8), .STAGES(4)) u_d84 (
        .clk(clk), .rst(rst), .x(x84), .y(y84), .cin(c84), .A(a84), .cout(co84));
    full_adder #(.WIDTH(8), .STAGES(2)) u_d82 (
        .clk(clk), .rst(rst), .x(x82), .y(y82), .cin(c82), .A(a82), .cout(co82));
    full_adder #(.WIDTH(16), .STAGES(4)) u_d164 (
        .clk(clk), .rst(rst), .x(x164), .y(y164), .cin(c164), .A(a164), .cout(co164));
    full_adder #(.WIDTH(8), .STAGES(8)) u_d88 (
        .clk(clk), .rst(rst), .x(x88), .y(y88), .cin(c88), .A(a88), .cout(co88));

    task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Sums for (x,y,cin) = 000..111, computed by hand.
    logic [1:0] tt [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};

    logic [16:0] h164 [0:399];
    logic [16:0] h88  [0:399];

    initial begin
        x1 = '0;  y1 = '0;  c1 = 1'b0;
        x84 = '0; y84 = '0; c84 = 1'b0;
        x82 = '0; y82 = '0; c82 = 1'b0;
        x164 = '0; y164 = '0; c164 = 1'b0;
        x88 = '0; y88 = '0; c88 = 1'b0;

        // Reset held for two cycles
        @(negedge clk);
        @(negedge clk);
        chk("rst_d1",  {co1, a1},  17'h0);
        chk("rst_d84", {co84, a84}, 17'h0);
        chk("rst_d164", {co164, a164}, 17'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_d1", {co1, a1}, 17'h0);
        chk("post_rst_d88", {co88, a88}, 17'h0);

        // Ordered truth-table vectors, then every combination
        x1 = 1'b1; y1 = 1'b1; c1 = 1'b1;
        @(negedge clk); chk("tt_111", {co1, a1}, 17'h3);
        x1 = 1'b0; y1 = 1'b1; c1 = 1'b0;
        @(negedge clk); chk("tt_010", {co1, a1}, 17'h1);
        x1 = 1'b1; y1 = 1'b0; c1 = 1'b1;
        @(negedge clk); chk("tt_101", {co1, a1}, 17'h2);
        for (int i = 0; i < 8; i++) begin
            x1 = 1'(i >> 2); y1 = 1'(i >> 1); c1 = 1'(i);
            @(negedge clk);
            chk($sformatf("tt_all_%0d", i), {co1, a1}, {15'h0, tt[i]});
        end

        // WIDTH=8 STAGES=4 back-to-back stream
        x84 = 8'hFF; y84 = 8'h01; c84 = 1'b0;
        @(negedge clk); x84 = 8'h7F; y84 = 8'h80; c84 = 1'b1;
        @(negedge clk); x84 = 8'h12; y84 = 8'h34; c84 = 1'b1;
        @(negedge clk); chk("s84_early", {co84, a84}, 17'h0);
        x84 = 8'h00; y84 = 8'h00; c84 = 1'b0;
        @(negedge clk); chk("s84_op0", {co84, a84}, 17'h100);
        @(negedge clk); chk("s84_op1", {co84, a84}, 17'h100);
        @(negedge clk); chk("s84_op2", {co84, a84}, 17'h047);
        @(negedge clk); chk("s84_tail", {co84, a84}, 17'h0);

        // WIDTH=8 STAGES=2 carry crossing the stage boundary
        x82 = 8'h0F; y82 = 8'hF0; c82 = 1'b1;
        @(negedge clk); chk("s82_early", {co82, a82}, 17'h0);
        x82 = 8'h00; y82 = 8'h00; c82 = 1'b0;
        @(negedge clk); chk("s82_ripple", {co82, a82}, 17'h100);

        // Reset while three operations are in flight
        x84 = 8'h11; y84 = 8'h22; c84 = 1'b0;
        @(negedge clk); x84 = 8'hF0; y84 = 8'h20; c84 = 1'b1;
        @(negedge clk); x84 = 8'h55; y84 = 8'hAA; c84 = 1'b1;
        @(negedge clk); x84 = 8'h00; y84 = 8'h00; c84 = 1'b0; rst = 1'b1;
        @(negedge clk); chk("mid_rst_0", {co84, a84}, 17'h0);
        rst = 1'b0;
        x84 = 8'h80; y84 = 8'h81; c84 = 1'b1;
        @(negedge clk); chk("mid_rst_1", {co84, a84}, 17'h0);
        x84 = 8'h00; y84 = 8'h00; c84 = 1'b0;
        @(negedge clk); chk("mid_rst_2", {co84, a84}, 17'h0);
        @(negedge clk); chk("mid_rst_3", {co84, a84}, 17'h0);
        @(negedge clk); chk("mid_rst_new", {co84, a84}, 17'h102);

        // Randomized streams against a wide reference sum delayed by the pipeline depth
        for (int i = 0; i < 400; i++) begin
            if (i >= 4)  chk("rnd164", {co164, a164}, h164[i-4]);
            if (i >= 8)  chk("rnd88",  {8'h0, co88, a88}, h88[i-8]);
            if (i == 0) begin
                x164 = 16'hFFFF; y164 = 16'hFFFF; c164 = 1'b1;
                x88  = 8'hFF;    y88  = 8'hFF;    c88  = 1'b1;
            end else begin
                x164 = 16'($urandom); y164 = 16'($urandom); c164 = 1'($urandom);
                x88  = 8'($urandom);  y88  = 8'($urandom);  c88  = 1'($urandom);
            end
            h164[i] = 17'(x164) + 17'(y164) + 17'(c164);
            h88[i]  = 17'(x88) + 17'(y88) + 17'(c88);
            @(negedge clk);
        end
        chk("max164", h164[0], 17'h1FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/full_adder.md
# full_adder

Parameterizable, pipelined binary adder: x + y + cin → {cout, A}. The default configuration is a registered 1-bit full adder. It is the arithmetic leaf used by the co-simulation top-level. Operands are split into equal chunks; each chunk's ripple-carry add happens in its own pipeline stage. The block accepts one operand set per clock.

## Interface
Clock is `clk`. Reset is `rst`: synchronous, active-high. One clock domain.

Parameters:
- WIDTH, 1, operand/sum width in bits (≥1).
- STAGES, 1, pipeline depth. Requires 1 ≤ STAGES ≤ WIDTH and WIDTH % STAGES == 0. CHUNK = WIDTH/STAGES.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- x  in  WIDTH  operand A
- y  in  WIDTH  operand B
- cin  in  1  carry-in
- A  out  WIDTH  sum, registered
- cout  out  1  carry-out, registered

## Operation
- Result: {cout, A} = x + y + cin, computed in (WIDTH+1)-bit unsigned arithmetic with no overflow loss.
  - Max case: all-ones + all-ones + 1 = {1, all-ones}.
- Inputs x, y and cin are sampled on every rising clk edge. There is no valid or handshake; every cycle is a new operation.
- Stage s (0..STAGES-1) adds chunk s of x and y (bits s·CHUNK .. s·CHUNK+CHUNK-1) plus the carry from stage s-1. Stage 0 uses cin.
- Stage s registers two things:
  - its chunk sum, which is delayed through deskew registers so all chunks of one operation emerge together;
  - its chunk carry-out.
- Upper operand chunks are skewed through delay registers so each chunk reaches its stage in the same cycle as its incoming carry.
- The carry from the last stage drives cout.
- Inside each chunk the add is a ripple chain of 1-bit cells:
  - sum = a ^ b ^ c
  - carry = (a & b) | (a & c) | (b & c)
- X/Z on any input bit may propagate to the outputs. No X-scrubbing is done.
- Reset:
  - every pipeline, skew and deskew register clears to 0, so A = 0 and cout = 0;
  - reset has priority over the input capture for that edge;
  - an operation in flight when reset is asserted is discarded and never appears at the outputs.

## Timing
- Latency is exactly STAGES clock cycles. Operands present before edge n appear on A/cout immediately after edge n+STAGES-1.
  - Default: the result is visible right after the edge that samples the inputs.
- Throughput is 1 operation per cycle. Back-to-back operands yield back-to-back results in order, with no bubbles.
- During reset and for STAGES-1 cycles after rst deasserts, outputs are 0 unless valid pipelined data has reached them. Pipeline contents are zero-initialized by reset; zero operands produce A=0, cout=0, so the zero-fill is consistent.
- No combinational path from inputs to outputs.

## Structure
- Sub-module `full_adder_cell`: combinational 1-bit cell (a, b, c → s, co).
  - Each stage instantiates CHUNK cells in a generate loop.
- Top level contains:
  - the chunk generate loop;
  - skew shift registers: chunk s delayed s cycles;
  - deskew shift registers: chunk s delayed STAGES-1-s cycles;
  - inter-stage carry flops.
- Parameter legality is checked with an elaboration-time assertion. No shared package is needed.
  - If the codebase keeps a common package, CHUNK may be derived there as a localparam function.

## Test plan
- Default config, rst for 2 cycles: A=0, cout=0 during reset and after reset with x=y=cin=0.
- Default config, truth-table sequence, each checked one edge after application:
  - x=1,y=1,cin=1 → A=1, cout=1
  - x=0,y=1,cin=0 → A=1, cout=0
  - x=1,y=0,cin=1 → A=0, cout=1
  - exhaustively all 8 combinations.
- WIDTH=8, STAGES=4, back-to-back stream of 0xFF+0x01+0 → {1,0x00}, 0x7F+0x80+1 → {1,0x00}, 0x12+0x34+1 → {0,0x47}, each emerging exactly 4 cycles after sampling, consecutively.
- WIDTH=8, STAGES=2, full carry ripple across the stage boundary: 0x0F+0xF0+1 → A=0x00, cout=1 after 2 cycles.
- Reset mid-stream, WIDTH=8, STAGES=4: launch 3 ops, assert rst for 1 cycle → none of the in-flight results appear; outputs 0 until new post-reset ops arrive 4 cycles later.
- Randomized 10k ops per legal (WIDTH, STAGES) in {1,4,8,16}×divisors, compared against a (WIDTH+1)-bit reference delayed STAGES cycles.
